button_repeat_detector: RTL and testbench

- Parametrised successor of the front-panel push-button edge detector.
- Synchronises and debounces N_BTN raw button inputs.
- Emits one-cycle press/release pulses per channel, plus optional auto-repeat pulses while a button is held (e.g. held left/right/down in the game logic).
- Sits between the board button pins and the game control FSM, in the pixel/system clock domain.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/button_chan.sv | 118 +++++++++++
 rtl/button_repeat_detector.sv | 55 +++++
 tb/tb_button_repeat_detector.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button front end.
package btn_pkg;

  localparam int unsigned BTN_N_DEF             = 5;
  localparam int unsigned BTN_SYNC_DEF          = 2;
  localparam int unsigned BTN_DEBOUNCE_DEF      = 16;
  localparam int unsigned BTN_REPEAT_DELAY_DEF  = 20;
  localparam int unsigned BTN_REPEAT_PERIOD_DEF = 8;

  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_E = 1;
  localparam int unsigned BTN_W = 2;
  localparam int unsigned BTN_S = 3;
  localparam int unsigned BTN_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

endpackage

// File: rtl/button_chan.sv
// One button channel: synchroniser, debounce counter and auto-repeat FSM.
module button_chan
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = BTN_SYNC_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_button,
  input  logic i_rep_en,
  output logic o_level,
  output logic o_pls_press,
  output logic o_pls_release,
  output logic o_pls_repeat,
  output logic o_press_nxt
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_dcnt;
  logic [RW-1:0]          r_rcnt;
  rpt_state_e             r_state;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_repeat;

  logic w_s;
  logic w_flip;
  logic w_rise;
  logic w_fall;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_flip = (w_s != r_level) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_rise = w_flip & w_s;
  assign w_fall = w_flip & ~w_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_dcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_button};
      r_press   <= w_rise;
      r_release <= w_fall;
      if (w_s == r_level) begin
        r_dcnt <= '0;
      end else if (w_flip) begin
        r_level <= w_s;
        r_dcnt  <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  // A debounced fall on this edge wins over a timer expiry: no repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= DELAY;
            r_rcnt  <= '0;
          end
        end
        DELAY: begin
          if (!r_level || w_fall) begin
            r_state <= IDLE;
          end else if (!i_rep_en) begin
            r_rcnt <= '0;
          end else if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
            r_repeat <= 1'b1;
            r_rcnt   <= '0;
            r_state  <= REPEAT;
          end else begin
            r_rcnt <= r_rcnt + RW'(1);
          end
        end
        REPEAT: begin
          if (!r_level || w_fall) begin
            r_state <= IDLE;
          end else if (!i_rep_en) begin
            r_state <= DELAY;
            r_rcnt  <= '0;
          end else if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
            r_repeat <= 1'b1;
            r_rcnt   <= '0;
          end else begin
            r_rcnt <= r_rcnt + RW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_level       = r_level;
  assign o_pls_press   = r_press;
  assign o_pls_release = r_release;
  assign o_pls_repeat  = r_repeat;
  assign o_press_nxt   = w_rise;

endmodule

// File: rtl/button_repeat_detector.sv
// Multi-channel debounced button edge detector with per-channel auto-repeat.
module button_repeat_detector
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = BTN_N_DEF,
  parameter int unsigned SYNC_STAGES     = BTN_SYNC_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_button,
  input  logic [N_BTN-1:0] i_rep_en,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_pls_press,
  output logic [N_BTN-1:0] o_pls_release,
  output logic [N_BTN-1:0] o_pls_repeat,
  output logic             o_any_press
);

  logic [N_BTN-1:0] w_press_nxt;
  logic             r_any_press;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_button     (i_button[g]),
      .i_rep_en     (i_rep_en[g]),
      .o_level      (o_level[g]),
      .o_pls_press  (o_pls_press[g]),
      .o_pls_release(o_pls_release[g]),
      .o_pls_repeat (o_pls_repeat[g]),
      .o_press_nxt  (w_press_nxt[g])
    );
  end

  // Registered from next-state press flags so it aligns with o_pls_press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_nxt;
    end
  end

  assign o_any_press = r_any_press;

endmodule

// File: tb/tb_button_repeat_detector.sv
// Directed bench for button_repeat_detector with short debounce/repeat timing.
module tb_button_repeat_detector;

  localparam int unsigned NB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] i_button;
  logic [NB-1:0] i_rep_en;
  logic [NB-1:0] o_level;
  logic [NB-1:0] o_pls_press;
  logic [NB-1:0] o_pls_release;
  logic [NB-1:0] o_pls_repeat;
  logic          o_any_press;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] e_lv, e_pr, e_rl, e_rp;
  logic          e_an;

  always #5 clk = ~clk;

  button_repeat_detector #(
    .N_BTN          (NB),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_button     (i_button),
    .i_rep_en     (i_rep_en),
    .o_level      (o_level),
    .o_pls_press  (o_pls_press),
    .o_pls_release(o_pls_release),
    .o_pls_repeat (o_pls_repeat),
    .o_any_press  (o_any_press)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " level"},   32'(o_level),       32'(e_lv));
    chk({tag, " press"},   32'(o_pls_press),   32'(e_pr));
    chk({tag, " release"}, 32'(o_pls_release), 32'(e_rl));
    chk({tag, " repeat"},  32'(o_pls_repeat),  32'(e_rp));
    chk({tag, " any"},     32'(o_any_press),   32'(e_an));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_zero();
    e_lv = '0; e_pr = '0; e_rl = '0; e_rp = '0; e_an = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    i_button = '0;
    i_rep_en = '1;
    repeat (3) tick();
    expect_zero();
    chk_all("reset");
    rst = 1'b0;
    repeat (3) tick();
    chk_all("post-reset idle");

    // Clean hold on ch0, dropped at raw cycle 46; debounced fall hits a repeat expiry.
    i_button = 5'b00001;
    for (int c = 1; c <= 60; c++) begin
      tick();
      e_lv = {4'b0, (c >= 6 && c < 52)};
      e_pr = {4'b0, (c == 6)};
      e_rl = {4'b0, (c == 52)};
      e_rp = {4'b0, (c >= 16 && c < 52 && ((c - 16) % 4) == 0)};
      e_an = (c == 6);
      chk_all($sformatf("t1 c%0d", c));
      if (c == 46) i_button = '0;
    end
    repeat (8) tick();

    // Bounce on ch1: never accepted.
    i_button = 5'b00010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      expect_zero();
      chk_all($sformatf("t2 c%0d", c));
      if (c == 3) i_button = '0;
      if (c == 4) i_button = 5'b00010;
      if (c == 7) i_button = '0;
    end
    repeat (4) tick();

    // ch2 with repeat disabled until cycle 30.
    i_rep_en = 5'b11011;
    i_button = 5'b00100;
    for (int c = 1; c <= 58; c++) begin
      tick();
      e_lv = {2'b0, (c >= 6 && c < 51), 2'b0};
      e_pr = {2'b0, (c == 6), 2'b0};
      e_rl = {2'b0, (c == 51), 2'b0};
      e_rp = {2'b0, (c == 40 || c == 44 || c == 48), 2'b0};
      e_an = (c == 6);
      chk_all($sformatf("t3 c%0d", c));
      if (c == 30) i_rep_en = '1;
      if (c == 45) i_button = '0;
    end
    repeat (4) tick();

    // ch3 and ch4 together; fall lands on the third repeat expiry.
    i_button = 5'b11000;
    for (int c = 1; c <= 34; c++) begin
      tick();
      e_lv = (c >= 6 && c < 24) ? 5'b11000 : 5'b00000;
      e_pr = (c == 6) ? 5'b11000 : 5'b00000;
      e_rl = (c == 24) ? 5'b11000 : 5'b00000;
      e_rp = (c == 16 || c == 20) ? 5'b11000 : 5'b00000;
      e_an = (c == 6);
      chk_all($sformatf("t4 c%0d", c));
      if (c == 18) i_button = '0;
    end
    repeat (4) tick();

    // Reset at cycle 18 while ch0 is held.
    i_button = 5'b00001;
    for (int c = 1; c <= 18; c++) begin
      tick();
      e_lv = {4'b0, (c >= 6)};
      e_pr = {4'b0, (c == 6)};
      e_rl = '0;
      e_rp = {4'b0, (c == 16)};
      e_an = (c == 6);
      chk_all($sformatf("t5 pre c%0d", c));
    end
    rst = 1'b1;
    #1;
    expect_zero();
    chk_all("t5 rst async");
    tick();
    chk_all("t5 rst hold1");
    tick();
    chk_all("t5 rst hold2");
    rst = 1'b0;
    for (int d = 1; d <= 34; d++) begin
      tick();
      e_lv = {4'b0, (d >= 6 && d < 32)};
      e_pr = {4'b0, (d == 6)};
      e_rl = {4'b0, (d == 32)};
      e_rp = {4'b0, (d >= 16 && d < 32 && ((d - 16) % 4) == 0)};
      e_an = (d == 6);
      chk_all($sformatf("t5 post d%0d", d));
      if (d == 26) i_button = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
